// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge
//   Turns framed byte commands from a UART into 32-bit bus reads and writes.
//   Frames are MSB-first:
//     write: 0x57 A3 A2 A1 A0 D3 D2 D1 D0  -> response 0x4B
//     read : 0x52 A3 A2 A1 A0              -> response D3 D2 D1 D0
//     other opcode                         -> response 0x3F
//   A received byte flagged with rx_error aborts the frame silently.
//
// Optional feature: define UART_BRIDGE_TIMEOUT_EN to abort a frame that stalls
// in ADDR/DATA for TIMEOUT_CYCLES clocks (timeout pulses, no response sent).
// Without the macro the bridge waits indefinitely and timeout is held at 0.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   rx_data/rx_avail/rx_error/rx_ack   UART receive byte handshake
//   tx_data/tx_wr/tx_busy   UART transmit byte handshake
//   mem_addr/mem_wdata/mem_wmask/mem_wstrb/mem_rstrb/mem_rdata/mem_rbusy/mem_wbusy
//                           32-bit bus master (word aligned)
//   busy                    frame in progress (any state but IDLE)
//   timeout                 one-cycle pulse on a timed-out frame
module uart_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    input  logic        rx_error,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_wstrb,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rbusy,
    input  logic        mem_wbusy,
    output logic        busy,
    output logic        timeout
);

    localparam logic [7:0] OP_WRITE    = 8'h57;
    localparam logic [7:0] OP_READ     = 8'h52;
    localparam logic [7:0] RSP_ACK     = 8'h4B;
    localparam logic [7:0] RSP_UNKNOWN = 8'h3F;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS_WR, BUS_RD, RESP} state_t;
    typedef enum logic [1:0] {TX_READY, TX_WAIT_HI, TX_WAIT_LO} tx_phase_t;

    state_t      state, state_next;
    tx_phase_t   tx_phase;
    logic [1:0]  byte_cnt;
    logic        op_write;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] resp_buf;
    logic [2:0]  resp_left;

    logic accept;
    logic timed_out;
    logic bus_wr_done;
    logic bus_rd_done;
    logic tx_issue;
    logic resp_done;

    // rx_ack gates acceptance so a byte still flagged available during the
    // ack cycle is not consumed twice.
    assign accept      = rx_avail && !rx_ack &&
                         (state == IDLE || state == ADDR || state == DATA);
    // Busy inputs are ignored in the strobe cycle itself.
    assign bus_wr_done = (state == BUS_WR) && !mem_wstrb && !mem_wbusy;
    assign bus_rd_done = (state == BUS_RD) && !mem_rstrb && !mem_rbusy;
    // A byte is only issued once the previous one has shown tx_busy high then low.
    assign tx_issue    = (state == RESP) && (tx_phase == TX_READY) &&
                         (resp_left != 3'd0) && !tx_busy;
    assign resp_done   = (state == RESP) && (tx_phase == TX_READY) &&
                         (resp_left == 3'd0);

    assign busy      = (state != IDLE);
    assign mem_addr  = addr_q & 32'hFFFF_FFFC;
    assign mem_wdata = wdata_q;
    assign mem_wmask = {4{mem_wstrb}};

`ifdef UART_BRIDGE_TIMEOUT_EN
    logic [31:0] timer;

    assign timed_out = (state == ADDR || state == DATA) && !accept &&
                       (timer == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk) begin
        if (reset || accept || !(state == ADDR || state == DATA)) begin
            timer <= '0;
        end else begin
            timer <= timer + 32'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timed_out          = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !rx_error) begin
                    state_next = (rx_data == OP_WRITE || rx_data == OP_READ) ? ADDR : RESP;
                end
            end
            ADDR: begin
                if (timed_out) begin
                    state_next = IDLE;
                end else if (accept) begin
                    if (rx_error) begin
                        state_next = IDLE;
                    end else if (byte_cnt == 2'd3) begin
                        state_next = op_write ? DATA : BUS_RD;
                    end
                end
            end
            DATA: begin
                if (timed_out) begin
                    state_next = IDLE;
                end else if (accept) begin
                    if (rx_error) begin
                        state_next = IDLE;
                    end else if (byte_cnt == 2'd3) begin
                        state_next = BUS_WR;
                    end
                end
            end
            BUS_WR: begin
                if (bus_wr_done) begin
                    state_next = RESP;
                end
            end
            BUS_RD: begin
                if (bus_rd_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ack    <= 1'b0;
            tx_wr     <= 1'b0;
            tx_data   <= '0;
            mem_wstrb <= 1'b0;
            mem_rstrb <= 1'b0;
            timeout   <= 1'b0;
            byte_cnt  <= '0;
            op_write  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            resp_buf  <= '0;
            resp_left <= '0;
            tx_phase  <= TX_READY;
        end else begin
            rx_ack    <= accept;
            tx_wr     <= tx_issue;
            mem_wstrb <= (state != BUS_WR) && (state_next == BUS_WR);
            mem_rstrb <= (state != BUS_RD) && (state_next == BUS_RD);
            timeout   <= timed_out;

            if (accept && !rx_error) begin
                case (state)
                    IDLE: begin
                        op_write  <= (rx_data == OP_WRITE);
                        byte_cnt  <= '0;
                        // Preloaded for the unknown-opcode case; read/write
                        // frames overwrite it before reaching RESP.
                        resp_buf  <= {RSP_UNKNOWN, 24'h0};
                        resp_left <= 3'd1;
                    end
                    ADDR: begin
                        addr_q   <= {addr_q[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                    DATA: begin
                        wdata_q  <= {wdata_q[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                    default: ;
                endcase
            end

            if (bus_wr_done) begin
                resp_buf  <= {RSP_ACK, 24'h0};
                resp_left <= 3'd1;
            end

            if (bus_rd_done) begin
                resp_buf  <= mem_rdata;
                resp_left <= 3'd4;
            end

            if (tx_issue) begin
                tx_data   <= resp_buf[31:24];
                resp_buf  <= {resp_buf[23:0], 8'h00};
                resp_left <= resp_left - 3'd1;
            end

            case (tx_phase)
                TX_READY:   if (tx_issue) tx_phase <= TX_WAIT_HI;
                TX_WAIT_HI: if (tx_busy)  tx_phase <= TX_WAIT_LO;
                TX_WAIT_LO: if (!tx_busy) tx_phase <= TX_READY;
                default:    tx_phase <= TX_READY;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge
//   Directed bench for uart_bus_bridge: a table of complete frames with
//   expected bus transactions and response bytes, plus hand-written sequences
//   for rx_error aborts, timeout behaviour and reset in the middle of a write.
//   Background models stand in for the UART transmitter and the bus slave.
module tb_uart_bus_bridge;

    localparam int unsigned TO = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_avail = 1'b0;
    logic        rx_error = 1'b0;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_wstrb;
    logic        mem_rstrb;
    logic [31:0] mem_rdata = '0;
    logic        mem_rbusy = 1'b0;
    logic        mem_wbusy = 1'b0;
    logic        busy;
    logic        timeout;

    uart_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_avail(rx_avail), .rx_error(rx_error), .rx_ack(rx_ack),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_wstrb(mem_wstrb), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
        .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy),
        .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // ---------------- models (sole writers of their variables) ----------------
    logic [7:0]  tx_log[$];
    bit          tx_pending = 1'b0;
    int unsigned tx_tick = 0;
    int unsigned tx_overlap = 0;
    int unsigned wstrb_cnt = 0;
    int unsigned rstrb_cnt = 0;
    int unsigned mask_bad = 0;
    int unsigned unstable = 0;
    int unsigned wcnt = 0;
    int unsigned rcnt = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_wmask = '0;
    logic [31:0] last_raddr = '0;

    // Written by the main sequence only.
    logic [31:0] rd_value = '0;
    int unsigned wbusy_len = 2;

    always @(negedge clk) begin
        if (reset) begin
            tx_pending = 1'b0;
            tx_busy    = 1'b0;
            mem_wbusy  = 1'b0;
            mem_rbusy  = 1'b0;
            wcnt       = 0;
            rcnt       = 0;
        end else begin
            // UART transmitter: busy rises one cycle after tx_wr, lasts 3 cycles.
            if (tx_wr) begin
                if (tx_pending) tx_overlap++;
                tx_log.push_back(tx_data);
                tx_pending = 1'b1;
                tx_tick    = 0;
            end else if (tx_pending) begin
                tx_tick++;
                tx_busy = (tx_tick >= 1 && tx_tick <= 3);
                if (tx_tick == 5) tx_pending = 1'b0;
            end
            // Bus slave, write side.
            if (mem_wstrb) begin
                wstrb_cnt++;
                last_waddr = mem_addr;
                last_wdata = mem_wdata;
                last_wmask = mem_wmask;
                mem_wbusy  = 1'b1;
                wcnt       = wbusy_len;
            end else begin
                if (mem_wmask != 4'b0000) mask_bad++;
                if (mem_wbusy) begin
                    if (mem_addr != last_waddr || mem_wdata != last_wdata) unstable++;
                    if (wcnt > 0) wcnt--;
                    if (wcnt == 0) mem_wbusy = 1'b0;
                end
            end
            // Bus slave, read side: data valid only once rbusy drops.
            if (mem_rstrb) begin
                rstrb_cnt++;
                last_raddr = mem_addr;
                mem_rbusy  = 1'b1;
                mem_rdata  = '0;
                rcnt       = 3;
            end else if (mem_rbusy) begin
                if (mem_addr != last_raddr) unstable++;
                rcnt--;
                if (rcnt == 0) begin
                    mem_rbusy = 1'b0;
                    mem_rdata = rd_value;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one byte and holds rx_avail through the ack cycle, as a UART
    // that clears its flag only after seeing rx_ack would.
    task automatic send_byte(input logic [7:0] b, input logic err);
        bit got;
        got = 1'b0;
        @(negedge clk);
        rx_data  = b;
        rx_error = err;
        rx_avail = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rx_ack) got = 1'b1;
        end
        check($sformatf("rx_ack for byte %h", b), {31'd0, got}, 32'd1);
        @(negedge clk);
        check($sformatf("rx_ack single cycle for byte %h", b), {31'd0, rx_ack}, 32'd0);
        rx_avail = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        check({tag, " returns idle"}, {31'd0, idle}, 32'd1);
    endtask

    typedef struct {
        logic [71:0] rx;     // frame bytes, MSB-first, left aligned
        int unsigned nrx;
        logic [31:0] rdata;  // value the bus slave returns
        int unsigned nw;     // expected write strobes
        int unsigned nr;     // expected read strobes
        logic [31:0] addr;   // expected bus address
        logic [31:0] wdata;  // expected write data
        logic [31:0] tx;     // expected response bytes, MSB-first
        int unsigned ntx;
    } vec_t;

    function automatic vec_t mk(input logic [71:0] rx, input int unsigned nrx,
                                input logic [31:0] rdata, input int unsigned nw,
                                input int unsigned nr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] tx,
                                input int unsigned ntx);
        vec_t v;
        v.rx = rx; v.nrx = nrx; v.rdata = rdata; v.nw = nw; v.nr = nr;
        v.addr = addr; v.wdata = wdata; v.tx = tx; v.ntx = ntx;
        return v;
    endfunction

    task automatic run_vector(input vec_t v, input string tag);
        int unsigned tx0, w0, r0;
        tx0 = tx_log.size();
        w0  = wstrb_cnt;
        r0  = rstrb_cnt;
        rd_value = v.rdata;
        for (int i = 0; i < int'(v.nrx); i++) send_byte(v.rx[71 - 8*i -: 8], 1'b0);
        wait_idle(tag);
        check({tag, " wstrb count"}, wstrb_cnt - w0, v.nw);
        check({tag, " rstrb count"}, rstrb_cnt - r0, v.nr);
        if (v.nw != 0) begin
            check({tag, " write addr"}, last_waddr, v.addr);
            check({tag, " write data"}, last_wdata, v.wdata);
            check({tag, " write mask"}, {28'd0, last_wmask}, 32'hF);
        end
        if (v.nr != 0) check({tag, " read addr"}, last_raddr, v.addr);
        check({tag, " tx count"}, tx_log.size() - tx0, v.ntx);
        for (int i = 0; i < int'(v.ntx); i++) begin
            if (tx0 + i < tx_log.size())
                check($sformatf("%s tx byte %0d", tag, i), {24'd0, tx_log[tx0 + i]},
                      {24'd0, v.tx[31 - 8*i -: 8]});
        end
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs[7];

    initial begin
        int unsigned tx0, w0, r0, pulses;
        bit seen;

        vecs[0] = mk(72'h57_00_00_10_04_DE_AD_BE_EF, 9, 32'h0, 1, 0,
                     32'h0000_1004, 32'hDEAD_BEEF, 32'h4B00_0000, 1);
        vecs[1] = mk(72'h52_00_00_10_07_00_00_00_00, 5, 32'h1234_5678, 0, 1,
                     32'h0000_1004, 32'h0, 32'h1234_5678, 4);
        vecs[2] = mk(72'h41_00_00_00_00_00_00_00_00, 1, 32'h0, 0, 0,
                     32'h0, 32'h0, 32'h3F00_0000, 1);
        vecs[3] = mk(72'h57_80_00_00_03_01_02_03_04, 9, 32'h0, 1, 0,
                     32'h8000_0000, 32'h0102_0304, 32'h4B00_0000, 1);
        vecs[4] = mk(72'h52_FF_FF_FF_FF_00_00_00_00, 5, 32'hA5A5_0F0F, 0, 1,
                     32'hFFFF_FFFC, 32'h0, 32'hA5A5_0F0F, 4);
        vecs[5] = mk(72'h53_00_00_00_00_00_00_00_00, 1, 32'h0, 0, 0,
                     32'h0, 32'h0, 32'h3F00_0000, 1);
        vecs[6] = mk(72'h57_FF_FF_FF_FE_FF_FF_FF_FF, 9, 32'h0, 1, 0,
                     32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h4B00_0000, 1);

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset control outputs",
              {22'd0, rx_ack, tx_wr, mem_wstrb, mem_rstrb, mem_wmask, busy, timeout}, 32'd0);
        check("reset tx_data", {24'd0, tx_data}, 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table of complete frames.
        for (int i = 0; i < $size(vecs); i++) run_vector(vecs[i], $sformatf("vec%0d", i));

        // rx_error on the opcode byte: discarded, nothing sent.
        tx0 = tx_log.size();
        send_byte(8'h57, 1'b1);
        check("err idle busy", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        check("err idle no tx", tx_log.size() - tx0, 32'd0);

        // rx_error mid-address: frame dropped, then a full read succeeds.
        w0 = wstrb_cnt; r0 = rstrb_cnt;
        send_byte(8'h57, 1'b0);
        send_byte(8'h00, 1'b0);
        check("err addr busy before", {31'd0, busy}, 32'd1);
        send_byte(8'h12, 1'b1);
        check("err addr busy after", {31'd0, busy}, 32'd0);
        repeat (30) @(negedge clk);
        check("err addr no tx", tx_log.size() - tx0, 32'd0);
        check("err addr no strobes", (wstrb_cnt - w0) + (rstrb_cnt - r0), 32'd0);
        run_vector(vecs[1], "after error");

`ifdef UART_BRIDGE_TIMEOUT_EN
        // Stalled frame times out TO cycles after the last accepted byte.
        tx0 = tx_log.size(); r0 = rstrb_cnt;
        send_byte(8'h52, 1'b0);
        send_byte(8'h00, 1'b0);
        seen = 1'b0;
        pulses = 0;
        for (int n = 1; n <= 300 && !seen; n++) begin
            @(negedge clk);
            if (timeout) begin
                seen = 1'b1;
                pulses = n + 1;
            end
        end
        check("timeout seen", {31'd0, seen}, 32'd1);
        check("timeout cycles", pulses, TO);
        check("timeout busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("timeout pulse width", {31'd0, timeout}, 32'd0);
        repeat (30) @(negedge clk);
        check("timeout no tx", tx_log.size() - tx0, 32'd0);
        check("timeout no rstrb", rstrb_cnt - r0, 32'd0);
        run_vector(vecs[1], "after timeout");
`else
        // Without the timeout feature a stalled frame waits and then completes.
        tx0 = tx_log.size(); r0 = rstrb_cnt;
        rd_value = 32'hCAFE_F00D;
        send_byte(8'h52, 1'b0);
        send_byte(8'h00, 1'b0);
        pulses = 0;
        for (int n = 0; n < 3 * TO; n++) begin
            @(negedge clk);
            if (timeout) pulses++;
        end
        check("stall no timeout pulse", pulses, 32'd0);
        check("stall still busy", {31'd0, busy}, 32'd1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h04, 1'b0);
        wait_idle("stall resume");
        check("stall read addr", last_raddr, 32'h0000_1004);
        check("stall rstrb count", rstrb_cnt - r0, 32'd1);
        check("stall tx count", tx_log.size() - tx0, 32'd4);
        if (tx_log.size() - tx0 == 4) begin
            check("stall tx bytes",
                  {tx_log[tx0], tx_log[tx0 + 1], tx_log[tx0 + 2], tx_log[tx0 + 3]},
                  32'hCAFE_F00D);
        end
`endif

        // Reset while BUS_WR is stalled on mem_wbusy.
        tx0 = tx_log.size(); w0 = wstrb_cnt; r0 = rstrb_cnt;
        wbusy_len = 40;
        send_byte(8'h57, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        check("rst strobe issued", wstrb_cnt - w0, 32'd1);
        check("rst waiting in bus write", {31'd0, busy}, 32'd1);
        check("rst wbusy held", {31'd0, mem_wbusy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst control outputs",
              {22'd0, rx_ack, tx_wr, mem_wstrb, mem_rstrb, mem_wmask, busy, timeout}, 32'd0);
        check("rst tx_data", {24'd0, tx_data}, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        wbusy_len = 2;
        repeat (60) @(negedge clk);
        check("rst no tx after release", tx_log.size() - tx0, 32'd0);
        check("rst no new strobes", (wstrb_cnt - w0) + (rstrb_cnt - r0), 32'd1);
        check("rst idle after release", {31'd0, busy}, 32'd0);
        run_vector(vecs[0], "after reset");

        // Properties watched by the models across the whole run.
        check("tx_wr before previous byte finished", tx_overlap, 32'd0);
        check("wmask outside strobe", mask_bad, 32'd0);
        check("bus addr/data changed mid transaction", unstable, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_bus_bridge.md
UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2700000, meaning the inter-byte timeout in clk cycles.
REQ-002 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports rx_data  input  8, rx_avail  input  1, rx_error  input  1, rx_ack  output  1; these form the UART receive byte interface.
REQ-005 SHALL have ports tx_data  output  8, tx_wr  output  1, tx_busy  input  1; these form the UART transmit byte interface.
REQ-006 SHALL have ports mem_addr  output  32, mem_wdata  output  32, mem_wmask  output  4, mem_wstrb  output  1, mem_rstrb  output  1, mem_rdata  input  32, mem_rbusy  input  1, mem_wbusy  input  1; these form the bus master.
REQ-007 SHALL have ports busy  output  1 (frame in progress) and timeout  output  1 (one-cycle pulse on frame abort).

Function
REQ-008 SHALL implement these frames, all fields MSB-first:
- write: 0x57, A3..A0, D3..D0; response 0x4B.
- read: 0x52, A3..A0; response D3..D0.
REQ-009 SHALL, when rx_avail=1 and rx_ack=0 in a byte-accepting state, latch rx_data that cycle and drive rx_ack=1 for exactly the next cycle; rx_avail SHALL be ignored while rx_ack=1 (no double consumption).
REQ-010 SHALL implement FSM states IDLE, ADDR, DATA, BUS_WR, BUS_RD, RESP; only IDLE, ADDR and DATA accept bytes.
REQ-011 SHALL, in IDLE, go to ADDR on 0x57/0x52 (opcode latched), and on any other byte go to RESP with one response byte 0x3F.
REQ-012 SHALL use a 2-bit byte counter that wraps 3->0 to end each field: ADDR->DATA (write) or ADDR->BUS_RD (read); DATA->BUS_WR.
REQ-013 SHALL force mem_addr[1:0]=2'b00 and drive mem_wmask=4'b1111 only in the mem_wstrb cycle, else 4'b0000.
REQ-014 SHALL, in BUS_WR, pulse mem_wstrb for one cycle on entry, wait while mem_wbusy=1, then go to RESP with byte 0x4B.
REQ-015 SHALL, in BUS_RD, pulse mem_rstrb for one cycle, capture mem_rdata in the first cycle after the strobe with mem_rbusy=0, then go to RESP with 4 bytes.
REQ-016 SHALL, in RESP, drive tx_wr for one cycle only when tx_busy=0, and SHALL NOT issue the next tx_wr until tx_busy has been seen 1 and then 0; after the last byte it SHALL go to IDLE.
REQ-017 SHALL, when rx_error=1 with rx_avail=1 in IDLE/ADDR/DATA, ack the byte, discard it and return to IDLE with no response.
REQ-018 SHALL drive busy=1 in every state except IDLE.
REQ-019 SHALL hold mem_addr and mem_wdata stable from the strobe until the bus transaction completes.

Reset
REQ-020 SHALL, on reset (including mid-frame or mid-bus-cycle), go to IDLE and clear the byte counter; rx_ack, tx_wr, mem_wstrb, mem_rstrb, mem_wmask, busy and timeout SHALL be 0; tx_data, mem_addr and mem_wdata SHALL be 0.
REQ-021 SHALL NOT complete any pending bus strobe or tx_wr after reset is released.

Configuration
REQ-022 SHALL, with UART_BRIDGE_TIMEOUT_EN defined, count cycles in ADDR/DATA since the last accepted byte; when the count reaches TIMEOUT_CYCLES the bridge SHALL go to IDLE, pulse timeout for 1 cycle and send no response.
REQ-023 SHALL, without UART_BRIDGE_TIMEOUT_EN, omit the counter, tie timeout to 0 and wait indefinitely in ADDR/DATA.

Verification
REQ-024 SHALL cover write: bytes 57 00 00 10 04 DE AD BE EF -> one mem_wstrb with mem_addr=0x00001004, mem_wdata=0xDEADBEEF, mask 1111; then tx byte 4B.
REQ-025 SHALL cover read: bytes 52 00 00 10 07 with mem_rdata=0x12345678 and mem_rbusy high for 3 cycles -> mem_addr=0x00001004; tx 12 34 56 78 in order.
REQ-026 SHALL cover an unknown opcode: byte 41 -> tx 3F only, no bus strobe.
REQ-027 SHALL cover rx_error: 57 00 then a byte with rx_error=1 -> IDLE, no tx; a following full read frame SHALL succeed.
REQ-028 SHALL cover timeout (macro defined, TIMEOUT_CYCLES=100): 52 00 then silence -> timeout pulse at 100 cycles, busy=0, no tx.
REQ-029 SHALL cover reset asserted during BUS_WR with mem_wbusy=1 -> all outputs 0 next cycle; no 4B is ever sent.
